seg_scan_capture: RTL

Capture and decode block for a multiplexed 4-digit, active-low seven-segment bus. It is the reader for the display side of the 4-digit counter: it samples the anode and segment lines driven to the display, and qualifies each digit strobe once it has been stable long enough. Each segment pattern is decoded back to a 4-bit digit, and the decoded value is published as a 16-bit BCD word once all four digits of a frame have been captured. Intended uses are loop-back checking on hardware and self-checking benches.

---
 rtl/seg_scan_capture.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_capture.sv
// seg_scan_capture: samples a multiplexed 4-digit active-low 7-seg bus, qualifies stable digit strobes, decodes them and publishes a BCD frame.
// Latency: digit captured STABLE_CYCLES+1 edges after its first sampling edge; frame published one edge after the fourth capture.
// Backpressure: none, passive observer. Optional macro SEG_CAPTURE_ERR_EN: invalid patterns decode to 4'hF and are flagged in digit_err.
module seg_scan_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  output logic [15:0] digits,
  output logic        frame_valid,
  output logic [3:0]  digit_err
);

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

  typedef enum logic {ST_WAIT, ST_HOLD} state_t;

  logic [10:0]     s1_q, s2_q;
  logic [7:0]      cnt_q, cnt_d;
  state_t          state_q, state_d;
  logic [3:0]      flag_q, flag_d;
  logic [3:0][3:0] val_q, val_d;
  logic [15:0]     digits_q, digits_d;
  logic            fv_q, fv_d;

  logic            stable;
  logic            capture;
  logic            strobe_ok;
  logic [1:0]      cap_idx;
  logic [3:0]      dec_val;

`ifdef SEG_CAPTURE_ERR_EN
  logic [3:0]      err_q, err_d;
  logic [3:0]      derr_q, derr_d;
  logic            dec_err;
`endif

  // s1_q is the value s2_q takes on the next edge, so comparing them detects a change of s2
  assign stable = (s1_q == s2_q);

  // Two-flop synchronizer; reset to the blank pattern so no strobe is seen out of reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= '1;
      s2_q <= '1;
    end else begin
      s1_q <= {an, seg};
      s2_q <= s1_q;
    end
  end

  // Strobe qualification: only a single active anode selects a slot
  always_comb begin
    strobe_ok = 1'b1;
    cap_idx   = 2'd0;
    case (s2_q[10:7])
      4'b1110: cap_idx = 2'd0;
      4'b1101: cap_idx = 2'd1;
      4'b1011: cap_idx = 2'd2;
      4'b0111: cap_idx = 2'd3;
      default: strobe_ok = 1'b0;
    endcase
  end

  // Segment pattern decode back to a digit value
  always_comb begin
    dec_val = 4'h0;
`ifdef SEG_CAPTURE_ERR_EN
    dec_err = 1'b0;
`endif
    case (s2_q[6:0])
      7'b0000001: dec_val = 4'd0;
      7'b1001111: dec_val = 4'd1;
      7'b0010010: dec_val = 4'd2;
      7'b0000110: dec_val = 4'd3;
      7'b1001100: dec_val = 4'd4;
      7'b0100100: dec_val = 4'd5;
      7'b0100000: dec_val = 4'd6;
      7'b0001111: dec_val = 4'd7;
      7'b0000000: dec_val = 4'd8;
      7'b0000100: dec_val = 4'd9;
      default: begin
`ifdef SEG_CAPTURE_ERR_EN
        dec_val = 4'hF;
        dec_err = 1'b1;
`else
        dec_val = 4'h0;
`endif
      end
    endcase
  end

  // Stable counter, capture FSM, slot and frame next-state logic
  always_comb begin
    cnt_d    = cnt_q;
    state_d  = state_q;
    flag_d   = flag_q;
    val_d    = val_q;
    digits_d = digits_q;
    fv_d     = 1'b0;
    capture  = 1'b0;
`ifdef SEG_CAPTURE_ERR_EN
    err_d    = err_q;
    derr_d   = derr_q;
`endif

    if (!stable)                 cnt_d = 8'd0;
    else if (cnt_q != STABLE_MAX) cnt_d = cnt_q + 8'd1;

    case (state_q)
      ST_WAIT: begin
        if (stable && (cnt_d == STABLE_MAX) && (cnt_q != STABLE_MAX) && strobe_ok) begin
          capture = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!stable) state_d = ST_WAIT;
      end
      default: state_d = ST_WAIT;
    endcase

    // Publish first so a capture on the same edge survives as the new frame's first slot
    if (&flag_q) begin
      digits_d = val_q;
      fv_d     = 1'b1;
      flag_d   = 4'b0000;
`ifdef SEG_CAPTURE_ERR_EN
      derr_d   = err_q;
`endif
    end

    if (capture) begin
      flag_d[cap_idx] = 1'b1;
      val_d[cap_idx]  = dec_val;
`ifdef SEG_CAPTURE_ERR_EN
      err_d[cap_idx]  = dec_err;
`endif
    end
  end

  // State, slot and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= 8'd0;
      state_q  <= ST_WAIT;
      flag_q   <= 4'b0000;
      val_q    <= '0;
      digits_q <= 16'h0000;
      fv_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      flag_q   <= flag_d;
      val_q    <= val_d;
      digits_q <= digits_d;
      fv_q     <= fv_d;
    end
  end

`ifdef SEG_CAPTURE_ERR_EN
  // Per-slot error bits and the per-frame error report
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q  <= 4'b0000;
      derr_q <= 4'b0000;
    end else begin
      err_q  <= err_d;
      derr_q <= derr_d;
    end
  end
  assign digit_err = derr_q;
`else
  assign digit_err = 4'b0000;
`endif

  assign digits      = digits_q;
  assign frame_valid = fv_q;

endmodule
